// File: rtl/demux_1xn_reg.sv
// ============================================================================
// demux_1xn_reg
// ----------------------------------------------------------------------------
// Registered 1:N streaming demultiplexer with valid/ready on the input and on
// every output channel. Each channel owns one output register. The target
// channel comes from `sel` in addressed mode or from an internal round-robin
// pointer in round-robin mode.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   mode       0 = addressed (route by sel), 1 = round-robin (route by rr_ptr)
//   in_valid   producer has a word
//   in_data    input word
//   sel        target channel in addressed mode
//   in_ready   word is accepted this cycle (combinational)
//   out_valid  per-channel valid, bit k is channel k
//   out_data   channel k occupies [k*WIDTH +: WIDTH]; idle channels read zero
//   out_ready  per-channel consumer ready
//   rr_ptr     current round-robin pointer
//   sel_err    one-cycle pulse after an addressed word with sel >= N was dropped
// ============================================================================
module demux_1xn_reg #(
    parameter int  WIDTH = 8,
    parameter int  N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SEL_W-1:0]     sel,
    output logic                 in_ready,
    output logic [N-1:0]         out_valid,
    output logic [N*WIDTH-1:0]   out_data,
    input  logic [N-1:0]         out_ready,
    output logic [SEL_W-1:0]     rr_ptr,
    output logic                 sel_err
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

    logic [SEL_W-1:0]          target;
    logic [N-1:0]              hit;
    logic [N-1:0]              free;
    logic [N-1:0]              load;
    logic                      accept;
    logic                      drop;
    logic [N-1:0][WIDTH-1:0]   data_q;

    // One-hot decode of the target channel. An out-of-range addressed
    // select (only possible when N is not a power of 2) decodes to all-zero.
    // NOTE: every always_comb output gets a default before any conditional
    // assignment so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        target = mode ? rr_ptr : sel;
        hit    = '0;
        for (int k = 0; k < N; k++) begin
            hit[k] = (target == SEL_W'(k));
        end
    end

    // A channel can take a new word if it is empty or being drained now.
    assign free     = ~out_valid | out_ready;
    // An unmapped select is always accepted so the producer never deadlocks.
    assign in_ready = (~|hit) | (|(hit & free));
    assign accept   = in_valid & in_ready;
    assign load     = {N{accept}} & hit;
    assign drop     = accept & ~|hit;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    // The data registers are reset as well because an idle channel must
    // present zero data, not stale contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= '0;
            data_q    <= '0;
            rr_ptr    <= '0;
            sel_err   <= 1'b0;
        end else begin
            sel_err <= drop;

            // In round-robin mode the target is always in range, so an
            // accept always lands on a channel and the pointer may advance.
            if (accept && mode) begin
                rr_ptr <= (rr_ptr == LAST) ? '0 : rr_ptr + SEL_W'(1);
            end

            for (int k = 0; k < N; k++) begin
                if (load[k]) begin
                    // Covers simultaneous drain+accept: new word replaces
                    // the old one and valid stays high.
                    data_q[k]    <= in_data;
                    out_valid[k] <= 1'b1;
                end else if (out_valid[k] && out_ready[k]) begin
                    data_q[k]    <= '0;
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign out_data = data_q;

endmodule

// File: tb/tb_demux_1xn_reg.sv
// ============================================================================
// tb_demux_1xn_reg
// ----------------------------------------------------------------------------
// Drives two instances side by side: N=4 (power of two) and N=3 (has an
// unmapped select value). Both share mode/in_valid/in_data/sel and have
// independent out_ready. A behavioural channel model predicts every output.
// ============================================================================
module tb_demux_1xn_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic [1:0]  sel = '0;
    logic [3:0]  rdy4 = 4'hF;
    logic [2:0]  rdy3 = 3'h7;

    logic        ir4, ir3;
    logic [3:0]  ov4;
    logic [2:0]  ov3;
    logic [31:0] od4;
    logic [23:0] od3;
    logic [1:0]  rp4, rp3;
    logic        se4, se3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    demux_1xn_reg #(.WIDTH(8), .N(4)) dut4 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid),
        .in_data(in_data), .sel(sel), .in_ready(ir4), .out_valid(ov4),
        .out_data(od4), .out_ready(rdy4), .rr_ptr(rp4), .sel_err(se4)
    );

    demux_1xn_reg #(.WIDTH(8), .N(3)) dut3 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid),
        .in_data(in_data), .sel(sel), .in_ready(ir3), .out_valid(ov3),
        .out_data(od3), .out_ready(rdy3), .rr_ptr(rp3), .sel_err(se3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    // Per instance: channel holds (valid, word), a pointer, an error flag.
    bit         mv  [2][4];
    logic [7:0] md  [2][4];
    int         ptr [2];
    bit         err [2];

    function automatic int nch(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    function automatic bit rdy_of(input int i, input int k);
        return (i == 0) ? rdy4[k] : rdy3[k];
    endfunction

    function automatic int target_of(input int i);
        return mode ? ptr[i] : int'(sel);
    endfunction

    function automatic bit exp_ready(input int i);
        int t;
        t = target_of(i);
        if (t >= nch(i)) return 1'b1;
        return !mv[i][t] || rdy_of(i, t);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                ptr[i] = 0;
                err[i] = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    mv[i][k] = 1'b0;
                    md[i][k] = '0;
                end
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int t;
                bit acc;
                t   = target_of(i);
                acc = in_valid && exp_ready(i);
                for (int k = 0; k < nch(i); k++) begin
                    if (acc && t == k) begin
                        mv[i][k] = 1'b1;
                        md[i][k] = in_data;
                    end else if (mv[i][k] && rdy_of(i, k)) begin
                        mv[i][k] = 1'b0;
                        md[i][k] = '0;
                    end
                end
                err[i] = acc && (t >= nch(i));
                if (acc && mode) ptr[i] = (ptr[i] + 1) % nch(i);
            end
        end
    end

    // -------------------------------------------------------------- compare
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [63:0] ev, ed;
            ev = '0;
            ed = '0;
            for (int k = 0; k < nch(i); k++) begin
                ev[k]       = mv[i][k];
                ed[k*8 +: 8] = md[i][k];
            end
            check($sformatf("n%0d_out_valid", nch(i)), (i == 0) ? 64'(ov4) : 64'(ov3), ev);
            check($sformatf("n%0d_out_data", nch(i)),  (i == 0) ? 64'(od4) : 64'(od3), ed);
            check($sformatf("n%0d_rr_ptr", nch(i)),    (i == 0) ? 64'(rp4) : 64'(rp3), 64'(ptr[i]));
            check($sformatf("n%0d_sel_err", nch(i)),   (i == 0) ? 64'(se4) : 64'(se3), 64'(err[i]));
            check($sformatf("n%0d_in_ready", nch(i)),  (i == 0) ? 64'(ir4) : 64'(ir3), 64'(exp_ready(i)));
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] saved_ov3;

    initial begin
        cyc();
        check("rst_out_valid", 64'(ov4), 64'h0);
        check("rst_rr_ptr",    64'(rp4), 64'h0);
        check("rst_sel_err",   64'(se4), 64'h0);
        cyc();
        rst = 1'b0;

        // Addressed routing, all consumers ready.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            sel      = 2'(i);
            in_data  = 8'hA1 + 8'(i);
            #1 check("addr_in_ready", 64'(ir4), 64'h1);
            cyc();
            check("addr_data",  64'(od4[i*8 +: 8]), 64'(8'hA1 + 8'(i)));
            check("addr_valid", 64'(ov4), 64'(4'b0001 << i));
        end
        in_valid = 1'b0;
        cyc();

        // Backpressure on channel 2.
        rdy4[2]  = 1'b0;
        in_valid = 1'b1;
        sel      = 2'd2;
        in_data  = 8'h55;
        cyc();
        in_data = 8'h66;
        #1 check("bp_in_ready_low", 64'(ir4), 64'h0);
        cyc();
        check("bp_hold_data", 64'(od4[23:16]), 64'h55);
        rdy4[2] = 1'b1;
        #1 check("bp_in_ready_high", 64'(ir4), 64'h1);
        cyc();
        check("bp_replace_data", 64'(od4[23:16]), 64'h66);
        check("bp_valid_kept",   64'(ov4[2]), 64'h1);
        in_valid = 1'b0;
        cyc();

        // Round-robin; channel 2 keeps its word so the 7th word stalls.
        mode    = 1'b1;
        rdy4[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h10 + 8'(i);
            cyc();
            check("rr_data", 64'(od4[(i % 4)*8 +: 8]), 64'(8'h10 + 8'(i)));
        end
        check("rr_ptr_end", 64'(rp4), 64'h2);
        in_data = 8'h16;
        for (int i = 0; i < 3; i++) begin
            #1 check("rr_stall_ready", 64'(ir4), 64'h0);
            cyc();
            check("rr_stall_ptr", 64'(rp4), 64'h2);
        end
        rdy4[2] = 1'b1;
        cyc();
        check("rr_unstall_data", 64'(od4[23:16]), 64'h16);
        check("rr_unstall_ptr",  64'(rp4), 64'h3);
        in_valid = 1'b0;
        cyc();

        // Asynchronous reset with channels 0 and 2 holding words.
        mode     = 1'b0;
        rdy4     = 4'b1010;
        in_valid = 1'b1;
        sel      = 2'd0;
        in_data  = 8'h31;
        cyc();
        sel     = 2'd2;
        in_data = 8'h32;
        cyc();
        check("pre_rst_valid", 64'(ov4), 64'b0101);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(ov4), 64'h0);
        check("async_rst_data",  64'(od4), 64'h0);
        check("async_rst_ptr",   64'(rp4), 64'h0);
        cyc();
        rst      = 1'b0;
        rdy4     = 4'hF;
        in_valid = 1'b1;
        sel      = 2'd1;
        in_data  = 8'h41;
        cyc();
        check("post_rst_valid", 64'(ov4), 64'b0010);
        check("post_rst_data",  64'(od4[15:8]), 64'h41);

        // Mode switch.
        mode    = 1'b1;
        in_data = 8'h50;
        cyc();
        in_data = 8'h51;
        cyc();
        check("ms_ptr2", 64'(rp4), 64'h2);
        mode    = 1'b0;
        sel     = 2'd0;
        in_data = 8'h52;
        cyc();
        check("ms_addr_data", 64'(od4[7:0]), 64'h52);
        check("ms_ptr_hold",  64'(rp4), 64'h2);
        mode    = 1'b1;
        in_data = 8'h53;
        cyc();
        check("ms_rr_data",  64'(od4[23:16]), 64'h53);
        check("ms_rr_valid", 64'(ov4), 64'b0100);
        in_valid = 1'b0;
        cyc();

        // Out-of-range select on the N=3 instance.
        mode     = 1'b0;
        sel      = 2'd3;
        in_data  = 8'hEE;
        in_valid = 1'b1;
        saved_ov3 = ov3;
        #1 check("oor_in_ready", 64'(ir3), 64'h1);
        cyc();
        check("oor_sel_err_hi", 64'(se3), 64'h1);
        check("oor_valid_same", 64'(ov3), 64'(saved_ov3));
        in_valid = 1'b0;
        cyc();
        check("oor_sel_err_lo", 64'(se3), 64'h0);

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 2000; n++) begin
            rst      = (($urandom % 200) == 0);
            mode     = (($urandom % 3) == 0);
            in_valid = (($urandom % 4) != 0);
            in_data  = 8'($urandom);
            sel      = 2'($urandom);
            rdy4     = 4'($urandom);
            rdy3     = 3'($urandom);
            cyc();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        rdy4     = 4'hF;
        rdy3     = 3'h7;
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_1xn_reg.md
Name: demux_1xn_reg

Overview:
- Parametrised, registered 1:N demultiplexer for streaming data with valid/ready handshake on the input and on each output channel.
- Successor to the combinational 1:2/1:4 demux blocks: configurable data width and channel count.
- Two routing modes: addressed (explicit select) and round-robin (internal pointer).
- One output register per channel. Sits between a single producer and N independent consumers.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- N, 4, number of output channels (2..16, need not be a power of 2).
- SEL_W, $clog2(N), select width; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- mode  input  1  0 = addressed (route by sel), 1 = round-robin (route by internal pointer).
- in_valid  input  1  producer has data.
- in_data  input  WIDTH  input word.
- sel  input  SEL_W  target channel in addressed mode; ignored in round-robin mode.
- in_ready  output  1  block accepts in_data this cycle.
- out_valid  output  N  per-channel valid; bit k belongs to channel k.
- out_data  output  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_ready  input  N  per-channel consumer ready.
- rr_ptr  output  SEL_W  current round-robin pointer (debug/visibility).
- sel_err  output  1  one-cycle pulse: addressed transfer with sel >= N was dropped.

Behaviour:
- Reset (async assert, sync release):
  - out_valid = 0 and all out_data = 0.
  - rr_ptr = 0, sel_err = 0.
  - Reset mid-transfer discards all held words. No partial state survives.
- Target channel t:
  - mode=0: t = sel.
  - mode=1: t = rr_ptr.
- Channel k is free when out_valid[k]==0 or out_ready[k]==1.
- in_ready (combinational from current state and inputs):
  - Valid t (< N): in_ready = free(t).
  - mode=0 and sel >= N: in_ready = 1.
- Accept occurs when in_valid && in_ready.
- On accept with valid t, at the next edge:
  - out_data[t] <= in_data.
  - out_valid[t] <= 1.
- Input-to-output latency: exactly 1 cycle.
- Drain: when out_valid[k] && out_ready[k] and channel k has no new accept, at the next edge out_valid[k] <= 0 and out_data[k] <= 0.
- Idle channels present zero data, matching the existing demux convention.
- Simultaneous drain and accept on the same channel:
  - The new word replaces the old one and out_valid stays 1.
  - Full throughput (1 word/cycle) to a single continuously-ready channel.
- Channels other than t hold their state. Only their own out_ready can drain them.
- Out-of-range select (mode=0, sel >= N; only possible when N is not a power of 2):
  - Word is accepted and dropped. No channel changes.
  - sel_err = 1 for the following cycle only.
- Round-robin pointer:
  - Advances only on an accepted transfer in mode=1.
  - Wraps from N-1 to 0.
  - Holds while stalled (target not free) and while mode=0.
  - A stall in round-robin mode blocks the input; no skipping to free channels.
- Mode change takes effect on the next cycle's target computation. In-flight output registers are unaffected.
- in_data and sel are sampled only on accept. Values outside accept cycles have no effect.
- All outputs except in_ready are registered.

Test Plan:
- Reset: assert rst mid-stream with out_valid=4'b0101 -> immediately out_valid=0, out_data=0, rr_ptr=0. After release, the first accept lands on the correct channel.
- Addressed routing: N=4, WIDTH=8, out_ready=4'b1111, send 0xA1..0xA4 with sel=0..3 on consecutive cycles -> each word appears on channel sel exactly one cycle later, others zero; in_ready constantly 1.
- Backpressure: out_ready[2]=0, send 0x55 then 0x66 to sel=2 -> 0x55 held on channel 2, in_ready=0 for the second word. Raise out_ready[2] -> 0x66 accepted the same cycle and replaces 0x55 next cycle, out_valid[2] stays 1.
- Round-robin: mode=1, all ready, 6 words 0x10..0x15 -> channels 0,1,2,3,0,1 receive them in order; rr_ptr ends at 2. Stall channel 2 -> in_ready=0, rr_ptr holds at 2 until ready.
- Out-of-range: N=3, mode=0, sel=3, in_data=0xEE -> in_ready=1, no out_valid change, sel_err pulses high for exactly one cycle.
- Mode switch: two round-robin accepts (rr_ptr=2), then mode=0 sel=0 word -> goes to channel 0. Return to mode=1 -> next word goes to channel 2.
